uram_cascade: RTL and testbench

//  Behavioural model of a dual-port UltraRAM cascade: NUM_URAM 4Kx72 tiles chained into one memory.
//  Two independent ports (A, B) on one clock; each does a read or a byte-masked write per enabled cycle.

---
 rtl/uram_cascade_pkg.sv | 34 +++
 rtl/uram_cascade_tile.sv | 43 ++++
 rtl/uram_cascade.sv | 128 ++++++++++++
 tb/tb_uram_cascade.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uram_cascade_pkg.sv
// Shared types and constants for the UltraRAM cascade model.
// Optional feature macro: URAM_CAS_OREG_EN (adds a second output register per port).
package uram_cascade_pkg;

  localparam int DATA_W     = 72;
  localparam int BYTE_W     = 8;
  localparam int NUM_BYTES  = 9;
  localparam int TILE_DEPTH = 4096;
  localparam int TILE_AW    = 12;
  localparam int ADDR_W     = 23;
  localparam int SEL_W      = ADDR_W - TILE_AW;

  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [NUM_BYTES-1:0] bwe_t;

  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    word_t             din;
    bwe_t              bwe;
  } port_req_t;

  // Replace the byte lanes of old_w selected by bwe with the lanes of new_w.
  function automatic word_t merge_bytes(word_t old_w, word_t new_w, bwe_t bwe);
    word_t res;
    res = old_w;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (bwe[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/uram_cascade_tile.sv
// One 4K x 72 dual-port tile with per-byte writes. Within a cycle port A's
// operation is ordered before port B's: B overwrites A on colliding lanes,
// B reads observe A's write, A reads observe the pre-write contents.
module uram_cascade_tile
  import uram_cascade_pkg::*;
(
  input  logic               clk,
  input  logic               we_a,
  input  logic [TILE_AW-1:0] addr_a,
  input  word_t              din_a,
  input  bwe_t               bwe_a,
  input  logic               we_b,
  input  logic [TILE_AW-1:0] addr_b,
  input  word_t              din_b,
  input  bwe_t               bwe_b,
  output word_t              rdata_a,
  output word_t              rdata_b
);

  word_t mem [TILE_DEPTH];

  // Byte-lane writes, port A first then port B.
  // NOTE: the array has no reset -- contents must survive rst, and a reset
  // loop over 4K words would also keep this from mapping onto a RAM macro.
  // NOTE: non-blocking writes; when both ports hit the same lane, the later
  // assignment (port B) is the one that lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_a && bwe_a[i]) mem[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
    end
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (we_b && bwe_b[i]) mem[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
    end
  end

  // Read data; port B forwards port A's same-cycle write to the same word.
  always_comb begin
    rdata_a = mem[addr_a];
    rdata_b = mem[addr_b];
    if (we_a && (addr_a == addr_b)) rdata_b = merge_bytes(rdata_b, din_a, bwe_a);
  end

endmodule

// File: rtl/uram_cascade.sv
// Dual-port UltraRAM cascade: NUM_URAM 4K x 72 tiles behind one address space.
// Requests are registered at the sampling edge and the memory is accessed on
// the following edge, giving one cycle of read latency.
// Define URAM_CAS_OREG_EN to add an output register per port (latency 2).
module uram_cascade
  import uram_cascade_pkg::*;
#(
  parameter int NUM_URAM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] DIN_A,
  input  logic [DATA_W-1:0] DIN_B,
  input  logic [NUM_BYTES-1:0] BWE_A,
  input  logic [NUM_BYTES-1:0] BWE_B,
  input  logic              RDB_WR_A,
  input  logic              RDB_WR_B,
  input  logic              EN_A,
  input  logic              EN_B,
  output logic [DATA_W-1:0] DOUT_A,
  output logic [DATA_W-1:0] DOUT_B,
  output logic              RDACCESS_A,
  output logic              RDACCESS_B
);

  localparam logic [SEL_W:0] NUM_URAM_L = (SEL_W+1)'(NUM_URAM);

  port_req_t          req_a, req_b;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               in_range_a, in_range_b;
  logic               rd_fire_a, rd_fire_b;
  word_t              rd_a, rd_b;
  word_t              tile_rd_a [NUM_URAM];
  word_t              tile_rd_b [NUM_URAM];

  // Input request registers; reset drops any pending access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_a <= '0;
      req_b <= '0;
    end else begin
      req_a <= '{en: EN_A, wr: RDB_WR_A, addr: ADDR_A, din: DIN_A, bwe: BWE_A};
      req_b <= '{en: EN_B, wr: RDB_WR_B, addr: ADDR_B, din: DIN_B, bwe: BWE_B};
    end
  end

  assign sel_a      = req_a.addr[ADDR_W-1:TILE_AW];
  assign sel_b      = req_b.addr[ADDR_W-1:TILE_AW];
  assign in_range_a = {1'b0, sel_a} < NUM_URAM_L;
  assign in_range_b = {1'b0, sel_b} < NUM_URAM_L;
  assign rd_fire_a  = req_a.en && !req_a.wr;
  assign rd_fire_b  = req_b.en && !req_b.wr;

  // Tile array; a write reaches a tile only when its index is selected,
  // so out-of-range writes touch nothing.
  for (genvar g = 0; g < NUM_URAM; g++) begin : g_tile
    uram_cascade_tile u_tile (
      .clk     (clk),
      .we_a    (req_a.en && req_a.wr && (sel_a == SEL_W'(g))),
      .addr_a  (req_a.addr[TILE_AW-1:0]),
      .din_a   (req_a.din),
      .bwe_a   (req_a.bwe),
      .we_b    (req_b.en && req_b.wr && (sel_b == SEL_W'(g))),
      .addr_b  (req_b.addr[TILE_AW-1:0]),
      .din_b   (req_b.din),
      .bwe_b   (req_b.bwe),
      .rdata_a (tile_rd_a[g]),
      .rdata_b (tile_rd_b[g])
    );
  end

  // Read-data mux across tiles; out-of-range selects leave zero.
  // NOTE: outputs get a default before the loop so no path infers a latch.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_URAM; i++) begin
      if (in_range_a && (sel_a == SEL_W'(i))) rd_a = tile_rd_a[i];
      if (in_range_b && (sel_b == SEL_W'(i))) rd_b = tile_rd_b[i];
    end
  end

`ifdef URAM_CAS_OREG_EN
  logic  s1_acc_a, s1_acc_b;
  word_t s1_dout_a, s1_dout_b;

  // Two-stage output pipeline; data and strobe move together, DOUT holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_acc_a   <= 1'b0;
      s1_acc_b   <= 1'b0;
      s1_dout_a  <= '0;
      s1_dout_b  <= '0;
      RDACCESS_A <= 1'b0;
      RDACCESS_B <= 1'b0;
      DOUT_A     <= '0;
      DOUT_B     <= '0;
    end else begin
      s1_acc_a   <= rd_fire_a;
      s1_acc_b   <= rd_fire_b;
      if (rd_fire_a) s1_dout_a <= rd_a;
      if (rd_fire_b) s1_dout_b <= rd_b;
      RDACCESS_A <= s1_acc_a;
      RDACCESS_B <= s1_acc_b;
      if (s1_acc_a) DOUT_A <= s1_dout_a;
      if (s1_acc_b) DOUT_B <= s1_dout_b;
    end
  end
`else
  // Single output register; DOUT changes only on a completed read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RDACCESS_A <= 1'b0;
      RDACCESS_B <= 1'b0;
      DOUT_A     <= '0;
      DOUT_B     <= '0;
    end else begin
      RDACCESS_A <= rd_fire_a;
      RDACCESS_B <= rd_fire_b;
      if (rd_fire_a) DOUT_A <= rd_a;
      if (rd_fire_b) DOUT_B <= rd_b;
    end
  end
`endif

endmodule

// File: tb/tb_uram_cascade.sv
// Self-checking bench for uram_cascade: directed scenarios plus a randomized
// two-port run against a word-level reference memory.
// Honors URAM_CAS_OREG_EN (expected read latency 2 instead of 1).
module tb_uram_cascade;
  import uram_cascade_pkg::*;

`ifdef URAM_CAS_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NUM_URAM = 16;
  localparam int NCYC     = 400;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] ADDR_A, ADDR_B;
  word_t             DIN_A, DIN_B;
  bwe_t              BWE_A, BWE_B;
  logic              RDB_WR_A, RDB_WR_B, EN_A, EN_B;
  word_t             DOUT_A, DOUT_B;
  logic              RDACCESS_A, RDACCESS_B;

  int pass_cnt  = 0;
  int total_cnt = 0;

  word_t mdl [int];

  uram_cascade #(.NUM_URAM(NUM_URAM)) dut (
    .clk        (clk),
    .rst        (rst),
    .ADDR_A     (ADDR_A),
    .ADDR_B     (ADDR_B),
    .DIN_A      (DIN_A),
    .DIN_B      (DIN_B),
    .BWE_A      (BWE_A),
    .BWE_B      (BWE_B),
    .RDB_WR_A   (RDB_WR_A),
    .RDB_WR_B   (RDB_WR_B),
    .EN_A       (EN_A),
    .EN_B       (EN_B),
    .DOUT_A     (DOUT_A),
    .DOUT_B     (DOUT_B),
    .RDACCESS_A (RDACCESS_A),
    .RDACCESS_B (RDACCESS_B)
  );

  always #5 clk = ~clk;

  function automatic word_t rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic wr, input logic [ADDR_W-1:0] addr,
                       input word_t din, input bwe_t bwe);
    EN_A = en; RDB_WR_A = wr; ADDR_A = addr; DIN_A = din; BWE_A = bwe;
  endtask

  task automatic set_b(input logic en, input logic wr, input logic [ADDR_W-1:0] addr,
                       input word_t din, input bwe_t bwe);
    EN_B = en; RDB_WR_B = wr; ADDR_B = addr; DIN_B = din; BWE_B = bwe;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0, '0);
  endtask

  // One write on the chosen port; reports whether any RDACCESS rose meanwhile.
  task automatic write_op(input bit port_b, input logic [ADDR_W-1:0] addr, input word_t din,
                          input bwe_t bwe, output logic acc_seen);
    if (port_b) set_b(1'b1, 1'b1, addr, din, bwe);
    else        set_a(1'b1, 1'b1, addr, din, bwe);
    tick();
    idle();
    acc_seen = RDACCESS_A | RDACCESS_B;
    for (int k = 0; k < LAT; k++) begin
      tick();
      acc_seen = acc_seen | RDACCESS_A | RDACCESS_B;
    end
  endtask

  // One read on the chosen port; returns the data and whether RDACCESS was a
  // single pulse exactly LAT cycles after the sampling edge.
  task automatic read_op(input bit port_b, input logic [ADDR_W-1:0] addr,
                         output word_t dout, output logic pulse_ok);
    logic early, at, late;
    if (port_b) set_b(1'b1, 1'b0, addr, '0, '0);
    else        set_a(1'b1, 1'b0, addr, '0, '0);
    tick();
    idle();
    early = port_b ? RDACCESS_B : RDACCESS_A;
    for (int k = 1; k < LAT; k++) begin
      tick();
      early = early | (port_b ? RDACCESS_B : RDACCESS_A);
    end
    tick();
    at   = port_b ? RDACCESS_B : RDACCESS_A;
    dout = port_b ? DOUT_B : DOUT_A;
    tick();
    late = port_b ? RDACCESS_B : RDACCESS_A;
    pulse_ok = !early && at && !late;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #12;
    total_cnt++;
    if ({DOUT_A, DOUT_B, RDACCESS_A, RDACCESS_B} !== '0)
      $display("FAIL reset_outputs: got %h/%h/%b/%b expected all zero",
               DOUT_A, DOUT_B, RDACCESS_A, RDACCESS_B);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({RDACCESS_A, RDACCESS_B} !== 2'b00)
      $display("FAIL reset_release_idle: got %b%b expected 00", RDACCESS_A, RDACCESS_B);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    word_t d;
    logic  acc, ok;
    write_op(1'b0, 23'h00FFFF, 72'h121112111211121121, 9'h1FF, acc);
    total_cnt++;
    if (acc !== 1'b0) $display("FAIL write_no_rdaccess: got %b expected 0", acc);
    else pass_cnt++;
    read_op(1'b0, 23'h00FFFF, d, ok);
    total_cnt++;
    if (d !== 72'h121112111211121121)
      $display("FAIL t1_dout_a: got %h expected %h", d, 72'h121112111211121121);
    else pass_cnt++;
    total_cnt++;
    if (ok !== 1'b1) $display("FAIL t1_rdaccess_pulse_a: got %b expected 1", ok);
    else pass_cnt++;
    read_op(1'b1, 23'h00FFFF, d, ok);
    total_cnt++;
    if (d !== 72'h121112111211121121 || ok !== 1'b1)
      $display("FAIL t1_read_b: got %h pulse %b expected %h pulse 1",
               d, ok, 72'h121112111211121121);
    else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    word_t d;
    logic  acc, ok;
    write_op(1'b0, 23'h000010, '0, 9'h1FF, acc);
    write_op(1'b0, 23'h000010, {DATA_W{1'b1}}, 9'h001, acc);
    read_op(1'b0, 23'h000010, d, ok);
    total_cnt++;
    if (d !== 72'hFF || ok !== 1'b1)
      $display("FAIL t2_lane0: got %h pulse %b expected %h pulse 1", d, ok, 72'hFF);
    else pass_cnt++;
    total_cnt++;
    if (DOUT_A !== 72'hFF) $display("FAIL t2_dout_hold: got %h expected %h", DOUT_A, 72'hFF);
    else pass_cnt++;
    write_op(1'b1, 23'h000010, {DATA_W{1'b1}}, 9'h000, acc);
    read_op(1'b1, 23'h000010, d, ok);
    total_cnt++;
    if (d !== 72'hFF) $display("FAIL t2_bwe_zero_noop: got %h expected %h", d, 72'hFF);
    else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    word_t d, expv;
    logic  ok;
    bwe_t  bb;
    // A write + B read, same word.
    set_a(1'b1, 1'b1, 23'h000020, {9{8'hAA}}, 9'h1FF);
    set_b(1'b1, 1'b0, 23'h000020, '0, '0);
    tick();
    idle();
    repeat (LAT) tick();
    total_cnt++;
    if (DOUT_B !== {9{8'hAA}} || RDACCESS_B !== 1'b1 || RDACCESS_A !== 1'b0)
      $display("FAIL t3_a_wr_b_rd: got %h acc %b/%b expected %h acc 0/1",
               DOUT_B, RDACCESS_A, RDACCESS_B, {9{8'hAA}});
    else pass_cnt++;
    // A read + B write, same word: A sees the old contents.
    set_a(1'b1, 1'b0, 23'h000020, '0, '0);
    set_b(1'b1, 1'b1, 23'h000020, {9{8'h55}}, 9'h1FF);
    tick();
    idle();
    repeat (LAT) tick();
    total_cnt++;
    if (DOUT_A !== {9{8'hAA}} || RDACCESS_A !== 1'b1)
      $display("FAIL t3_a_rd_b_wr: got %h acc %b expected %h acc 1",
               DOUT_A, RDACCESS_A, {9{8'hAA}});
    else pass_cnt++;
    read_op(1'b0, 23'h000020, d, ok);
    total_cnt++;
    if (d !== {9{8'h55}}) $display("FAIL t3_b_wr_landed: got %h expected %h", d, {9{8'h55}});
    else pass_cnt++;
    // Both write full words: B wins.
    set_a(1'b1, 1'b1, 23'h000020, {9{8'h11}}, 9'h1FF);
    set_b(1'b1, 1'b1, 23'h000020, {9{8'h22}}, 9'h1FF);
    tick();
    idle();
    read_op(1'b1, 23'h000020, d, ok);
    total_cnt++;
    if (d !== {9{8'h22}}) $display("FAIL t3_both_wr_full: got %h expected %h", d, {9{8'h22}});
    else pass_cnt++;
    // Both write, B on some lanes only: per-lane merge.
    bb = 9'h0F0;
    set_a(1'b1, 1'b1, 23'h000020, {9{8'h33}}, 9'h1FF);
    set_b(1'b1, 1'b1, 23'h000020, {9{8'h44}}, bb);
    tick();
    idle();
    for (int i = 0; i < NUM_BYTES; i++) expv[i*8 +: 8] = bb[i] ? 8'h44 : 8'h33;
    read_op(1'b0, 23'h000020, d, ok);
    total_cnt++;
    if (d !== expv) $display("FAIL t3_both_wr_partial: got %h expected %h", d, expv);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    word_t d;
    logic  acc, ok;
    write_op(1'b0, 23'h000000, 72'h0123456789ABCDEF01, 9'h1FF, acc);
    read_op(1'b0, 23'h000000, d, ok);
    write_op(1'b0, 23'h010000, {DATA_W{1'b1}}, 9'h1FF, acc);
    read_op(1'b0, 23'h010000, d, ok);
    total_cnt++;
    if (d !== '0 || ok !== 1'b1)
      $display("FAIL t4_oor_read: got %h pulse %b expected 0 pulse 1", d, ok);
    else pass_cnt++;
    read_op(1'b0, 23'h000000, d, ok);
    total_cnt++;
    if (d !== 72'h0123456789ABCDEF01)
      $display("FAIL t4_tile0_untouched: got %h expected %h", d, 72'h0123456789ABCDEF01);
    else pass_cnt++;
    read_op(1'b1, 23'h7FF123, d, ok);
    total_cnt++;
    if (d !== '0 || ok !== 1'b1)
      $display("FAIL t4_oor_top_b: got %h pulse %b expected 0 pulse 1", d, ok);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    word_t d;
    logic  acc, ok;
    write_op(1'b0, 23'h0000A0, 72'h5A5A00FF00FF5A5A77, 9'h1FF, acc);
    read_op(1'b0, 23'h0000A0, d, ok);
    set_a(1'b1, 1'b0, 23'h0000A0, '0, '0);
    tick();
    idle();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (DOUT_A !== '0 || RDACCESS_A !== 1'b0)
      $display("FAIL t5_async_clear: got %h acc %b expected 0 acc 0", DOUT_A, RDACCESS_A);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    acc = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      tick();
      acc = acc | RDACCESS_A;
    end
    total_cnt++;
    if (acc !== 1'b0 || DOUT_A !== '0)
      $display("FAIL t5_no_stale_access: got acc %b dout %h expected acc 0 dout 0", acc, DOUT_A);
    else pass_cnt++;
    read_op(1'b0, 23'h0000A0, d, ok);
    total_cnt++;
    if (d !== 72'h5A5A00FF00FF5A5A77 || ok !== 1'b1)
      $display("FAIL t5_mem_kept: got %h pulse %b expected %h pulse 1",
               d, ok, 72'h5A5A00FF00FF5A5A77);
    else pass_cnt++;
  endtask

  // Reference: A's op applied to the word memory, then B's; a read returns
  // the word at that moment (zero out of range).
  task automatic model_port(input logic en, input logic wr, input logic [ADDR_W-1:0] addr,
                            input word_t din, input bwe_t bwe,
                            output bit rd_v, output word_t rd_d);
    int  tile;
    bit  in_rng;
    tile   = int'(addr[ADDR_W-1:TILE_AW]);
    in_rng = tile < NUM_URAM;
    rd_v = 1'b0;
    rd_d = '0;
    if (en) begin
      if (wr) begin
        if (in_rng) begin
          for (int i = 0; i < NUM_BYTES; i++)
            if (bwe[i]) mdl[int'(addr)][i*8 +: 8] = din[i*8 +: 8];
        end
      end else begin
        rd_v = 1'b1;
        rd_d = in_rng ? mdl[int'(addr)] : '0;
      end
    end
  endtask

  task automatic test_random();
    int          tiles [5] = '{0, 1, 15, 16, 2047};
    bit          ev_a [NCYC+LAT];
    bit          ev_b [NCYC+LAT];
    word_t       ed_a [NCYC+LAT];
    word_t       ed_b [NCYC+LAT];
    word_t       hold_a, hold_b, w;
    logic        acc;
    logic        en_a, en_b, wr_a, wr_b, exp_acc_a, exp_acc_b;
    logic [ADDR_W-1:0] ad_a, ad_b;
    word_t       dn_a, dn_b;
    bwe_t        be_a, be_b;
    int          errs;

    // Reset pulse gives known held outputs; memory contents survive it.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    hold_a = '0;
    hold_b = '0;
    for (int t = 0; t < 3; t++) begin
      for (int wd = 0; wd < 8; wd++) begin
        w = rand_word();
        mdl[(tiles[t] << TILE_AW) + wd] = w;
        write_op(1'b0, ADDR_W'((tiles[t] << TILE_AW) + wd), w, 9'h1FF, acc);
      end
    end
    errs = 0;
    for (int c = 0; c < NCYC + LAT; c++) begin
      if (c < NCYC) begin
        en_a = ($urandom_range(0, 9) < 8);
        en_b = ($urandom_range(0, 9) < 8);
        wr_a = $urandom_range(0, 1) == 1;
        wr_b = $urandom_range(0, 1) == 1;
        ad_a = ADDR_W'((tiles[$urandom_range(0, 4)] << TILE_AW) + $urandom_range(0, 7));
        ad_b = ADDR_W'((tiles[$urandom_range(0, 4)] << TILE_AW) + $urandom_range(0, 7));
        dn_a = rand_word();
        dn_b = rand_word();
        be_a = bwe_t'($urandom_range(0, 511));
        be_b = bwe_t'($urandom_range(0, 511));
      end else begin
        en_a = 1'b0; en_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        ad_a = '0; ad_b = '0; dn_a = '0; dn_b = '0; be_a = '0; be_b = '0;
      end
      set_a(en_a, wr_a, ad_a, dn_a, be_a);
      set_b(en_b, wr_b, ad_b, dn_b, be_b);
      model_port(en_a, wr_a, ad_a, dn_a, be_a, ev_a[c], ed_a[c]);
      model_port(en_b, wr_b, ad_b, dn_b, be_b, ev_b[c], ed_b[c]);
      tick();
      exp_acc_a = (c >= LAT) ? ev_a[c-LAT] : 1'b0;
      exp_acc_b = (c >= LAT) ? ev_b[c-LAT] : 1'b0;
      if (exp_acc_a) hold_a = ed_a[c-LAT];
      if (exp_acc_b) hold_b = ed_b[c-LAT];
      total_cnt++;
      if (RDACCESS_A !== exp_acc_a || DOUT_A !== hold_a) begin
        if (errs < 10)
          $display("FAIL rand_port_a cycle %0d: got acc %b dout %h expected acc %b dout %h",
                   c, RDACCESS_A, DOUT_A, exp_acc_a, hold_a);
        errs++;
      end else pass_cnt++;
      total_cnt++;
      if (RDACCESS_B !== exp_acc_b || DOUT_B !== hold_b) begin
        if (errs < 10)
          $display("FAIL rand_port_b cycle %0d: got acc %b dout %h expected acc %b dout %h",
                   c, RDACCESS_B, DOUT_B, exp_acc_b, hold_b);
        errs++;
      end else pass_cnt++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
